mem_port_ctrl: RTL

- MEM-stage initiator for the single shared instruction/data memory port. The IF stage is the responder.
- Takes load/store requests from the EX/MEM pipeline register and drives MemRead, MemWrite, Address2 and WriteData into the IF stage.
- Asserts PCFreze_SH and an IF/ID bubble while it holds the port, then captures MemResult for write-back.
- Also owns the halt freeze, PowerFrezePC_SH.

---
 rtl/mem_port_pkg.sv | 14 +
 rtl/mem_wait_counter.sv | 31 +++
 rtl/mem_port_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the MEM-stage memory port controller.
package mem_port_pkg;

  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 16;
  localparam int WAIT_W         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } portState_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; sets how long the data access holds the port.
module mem_wait_counter
  import mem_port_pkg::*;
#(
  parameter int WIDTH = WAIT_W
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] countReg;

  always_ff @(posedge clk) begin
    if (!rest) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= loadValue;
    end else if (dec && (countReg != '0)) begin
      countReg <= countReg - 1'b1;
    end
  end

  assign count = countReg;
  assign zero  = (countReg == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// MEM-stage initiator for the shared instruction/data memory port, plus the halt freeze.
// Optional misaligned-access trap is enabled by defining MEM_PORT_MISALIGN_TRAP_EN.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              mem_req_rd,
  input  logic              mem_req_wr,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_wdata,
  input  logic              halt_req,
  output logic              mem_ack,
  output logic              mem_busy,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address2,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] MemResult,
  output logic              PCFreze_SH,
  output logic              PowerFrezePC_SH,
  output logic              ifid_bubble,
`ifdef MEM_PORT_MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid
);

  portState_t stateReg, stateNext;

  logic              memReadNext, memWriteNext;
  logic [ADDR_W-1:0] address2Next;
  logic [DATA_W-1:0] writeDataNext, loadDataNext;
  logic              pcFrezeNext, powerFrezeNext, bubbleNext, busyNext;
  logic              ackNext, loadValidNext;

  logic              cntLoad, cntDec, cntZero;
  logic [WAIT_W-1:0] cntLoadValue, cntValue;
  logic              reqAny, trapReq;

  assign reqAny = mem_req_rd | mem_req_wr;

`ifdef MEM_PORT_MISALIGN_TRAP_EN
  assign trapReq = mem_req_addr[0];
`else
  assign trapReq = 1'b0;
`endif

  // A trapped request is not forwarded, so it only needs a single-cycle ack.
  assign cntLoadValue = trapReq ? '0 : WAIT_W'(WAIT_CYCLES);

  mem_wait_counter #(
    .WIDTH(WAIT_W)
  ) waitCounter (
    .clk      (clk),
    .rest     (rest),
    .load     (cntLoad),
    .loadValue(cntLoadValue),
    .dec      (cntDec),
    .count    (cntValue),
    .zero     (cntZero)
  );

  always_ff @(posedge clk) begin
    if (!rest) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext      = stateReg;
    memReadNext    = 1'b0;
    memWriteNext   = 1'b0;
    address2Next   = Address2;
    writeDataNext  = WriteData;
    pcFrezeNext    = 1'b0;
    powerFrezeNext = 1'b0;
    bubbleNext     = 1'b0;
    busyNext       = 1'b0;
    ackNext        = 1'b0;
    loadDataNext   = load_data;
    loadValidNext  = 1'b0;
    cntLoad        = 1'b0;
    cntDec         = 1'b0;

    unique case (stateReg)
      IDLE: begin
        // A pending access wins over halt; halt is looked at again once back here.
        if (reqAny) begin
          stateNext     = ACCESS;
          address2Next  = mem_req_addr;
          writeDataNext = mem_req_wdata;
          busyNext      = 1'b1;
          cntLoad       = 1'b1;
          if (trapReq) begin
            ackNext = 1'b1;
          end else begin
            memReadNext  = mem_req_rd & ~mem_req_wr;
            memWriteNext = mem_req_wr;
            pcFrezeNext  = 1'b1;
            bubbleNext   = 1'b1;
            ackNext      = (WAIT_CYCLES == 0);
          end
        end else if (halt_req) begin
          stateNext      = HALTED;
          powerFrezeNext = 1'b1;
          bubbleNext     = 1'b1;
          busyNext       = 1'b1;
        end
      end

      ACCESS: begin
        if (cntZero) begin
          stateNext = IDLE;
          if (MemRead) begin
            loadDataNext  = MemResult;
            loadValidNext = 1'b1;
          end
        end else begin
          cntDec       = 1'b1;
          memReadNext  = MemRead;
          memWriteNext = MemWrite;
          pcFrezeNext  = PCFreze_SH;
          bubbleNext   = ifid_bubble;
          busyNext     = mem_busy;
          ackNext      = (cntValue == WAIT_W'(1));
        end
      end

      HALTED: begin
        powerFrezeNext = 1'b1;
        bubbleNext     = 1'b1;
        busyNext       = 1'b1;
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      MemRead         <= 1'b0;
      MemWrite        <= 1'b0;
      Address2        <= '0;
      WriteData       <= '0;
      PCFreze_SH      <= 1'b0;
      PowerFrezePC_SH <= 1'b0;
      ifid_bubble     <= 1'b0;
      mem_busy        <= 1'b0;
      mem_ack         <= 1'b0;
      load_data       <= '0;
      load_valid      <= 1'b0;
    end else begin
      MemRead         <= memReadNext;
      MemWrite        <= memWriteNext;
      Address2        <= address2Next;
      WriteData       <= writeDataNext;
      PCFreze_SH      <= pcFrezeNext;
      PowerFrezePC_SH <= powerFrezeNext;
      ifid_bubble     <= bubbleNext;
      mem_busy        <= busyNext;
      mem_ack         <= ackNext;
      load_data       <= loadDataNext;
      load_valid      <= loadValidNext;
    end
  end

`ifdef MEM_PORT_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rest) begin
      misalign_err <= 1'b0;
    end else if ((stateReg == IDLE) && reqAny && trapReq) begin
      misalign_err <= 1'b1;
    end
  end
`endif

endmodule
